// File: rtl/joker_spi_cmd.sv
// SPI pass-through for the J_CMD_SPI command: bytes 1..len-1 of an EP2 OUT packet are
// shifted to the flash (mode 0) and the bytes clocked back are returned as the EP1 IN reply.
module joker_spi_cmd #(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 512,
  parameter int CMD_ID  = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        buf_out_hasdata,
  input  logic [9:0]  buf_out_len,
  input  logic [7:0]  buf_out_q,
  output logic [10:0] buf_out_addr_o,
  output logic        buf_out_arm,
  input  logic        buf_out_arm_ack,
  output logic [10:0] usb_in_addr_o,
  output logic [7:0]  usb_in_data_o,
  output logic        usb_in_wren_o,
  input  logic        usb_in_ready,
  output logic        usb_in_commit,
  output logic [10:0] usb_in_commit_len,
  input  logic        usb_in_commit_ack,
  output logic        FLASH_SCLK,
  output logic        FLASH_MOSI,
  output logic        FLASH_nCS,
  input  logic        FLASH_MISO,
  output logic        busy
);

  localparam logic [7:0]  DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [10:0] MAX_L  = 11'(MAX_LEN);
  localparam logic [7:0]  CMD    = 8'(CMD_ID);

  typedef enum logic [3:0] {
    IDLE, RD_CMD, CHECK, RD_BYTE, SHIFT, STORE, CS_HOLD, COMMIT, ARM
  } state_t;

  state_t      state, state_nx;
  logic [10:0] len_r;
  logic [10:0] idx;
  logic [7:0]  cmd_r;
  logic        rd_wait;
  logic [7:0]  div_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_sh;
  logic [7:0]  rx_sh;

  logic bad, half_done, more;
  assign bad       = (cmd_r != CMD) || (len_r < 11'd2) || (len_r > MAX_L);
  assign half_done = (div_cnt == 8'd0);
  assign more      = ((idx + 11'd1) < len_r);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // CHECK uses nCS as its first-cycle marker: high means the packet is not yet validated.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (buf_out_hasdata && usb_in_ready) state_nx = RD_CMD;
      RD_CMD:  if (rd_wait) state_nx = CHECK;
      CHECK: begin
        if (FLASH_nCS) begin
          if (bad) state_nx = ARM;
        end else if (half_done) begin
          state_nx = RD_BYTE;
        end
      end
      RD_BYTE: if (rd_wait) state_nx = SHIFT;
      SHIFT:   if (half_done && FLASH_SCLK && (bit_cnt == 3'd7)) state_nx = STORE;
      STORE:   state_nx = more ? RD_BYTE : CS_HOLD;
      CS_HOLD: if (half_done) state_nx = COMMIT;
      COMMIT:  if (usb_in_commit_ack) state_nx = ARM;
      ARM:     if (buf_out_arm_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_out_addr_o    <= '0;
      buf_out_arm       <= 1'b0;
      usb_in_addr_o     <= '0;
      usb_in_data_o     <= '0;
      usb_in_wren_o     <= 1'b0;
      usb_in_commit     <= 1'b0;
      usb_in_commit_len <= '0;
      FLASH_SCLK        <= 1'b0;
      FLASH_MOSI        <= 1'b0;
      FLASH_nCS         <= 1'b1;
      len_r             <= '0;
      idx               <= '0;
      cmd_r             <= '0;
      rd_wait           <= 1'b0;
      div_cnt           <= '0;
      bit_cnt           <= '0;
      tx_sh             <= '0;
      rx_sh             <= '0;
    end else begin
      usb_in_wren_o <= 1'b0;
      case (state)
        IDLE: begin
          buf_out_addr_o <= '0;
          rd_wait        <= 1'b0;
          if (buf_out_hasdata && usb_in_ready) len_r <= {1'b0, buf_out_len};
        end
        RD_CMD: begin
          rd_wait <= ~rd_wait;
          if (rd_wait) cmd_r <= buf_out_q;
        end
        CHECK: begin
          if (FLASH_nCS) begin
            if (bad) begin
              buf_out_arm <= 1'b1;
            end else begin
              FLASH_nCS     <= 1'b0;
              usb_in_wren_o <= 1'b1;
              usb_in_addr_o <= '0;
              usb_in_data_o <= CMD;
              div_cnt       <= DIV_M1;
            end
          end else if (half_done) begin
            idx            <= 11'd1;
            buf_out_addr_o <= 11'd1;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        RD_BYTE: begin
          rd_wait <= ~rd_wait;
          if (rd_wait) begin
            tx_sh      <= buf_out_q;
            FLASH_MOSI <= buf_out_q[7];
            div_cnt    <= DIV_M1;
            bit_cnt    <= '0;
          end
        end
        SHIFT: begin
          if (!half_done) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            div_cnt <= DIV_M1;
            if (!FLASH_SCLK) begin
              FLASH_SCLK <= 1'b1;
              rx_sh      <= {rx_sh[6:0], FLASH_MISO};
            end else begin
              FLASH_SCLK <= 1'b0;
              if (bit_cnt == 3'd7) begin
                usb_in_wren_o <= 1'b1;
                usb_in_addr_o <= idx;
                usb_in_data_o <= rx_sh;
              end else begin
                bit_cnt    <= bit_cnt + 3'd1;
                tx_sh      <= {tx_sh[6:0], 1'b0};
                FLASH_MOSI <= tx_sh[6];
              end
            end
          end
        end
        STORE: begin
          if (more) begin
            idx            <= idx + 11'd1;
            buf_out_addr_o <= idx + 11'd1;
          end else begin
            div_cnt <= DIV_M1;
          end
        end
        CS_HOLD: begin
          if (half_done) begin
            FLASH_nCS         <= 1'b1;
            usb_in_commit     <= 1'b1;
            usb_in_commit_len <= len_r;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        COMMIT: begin
          if (usb_in_commit_ack) begin
            usb_in_commit <= 1'b0;
            buf_out_arm   <= 1'b1;
          end
        end
        ARM: begin
          if (buf_out_arm_ack) begin
            buf_out_arm    <= 1'b0;
            buf_out_addr_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_joker_spi_cmd.sv
// Bench for joker_spi_cmd: directed and random packets against a packet-level model,
// plus two extra instances (CLK_DIV=1, 4) whose SCLK timing is measured.
module tb_joker_spi_cmd;
  localparam int CMD  = 30;
  localparam int MAXL = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, rst_x, hasdata, ready;
  logic [9:0] len_in;
  logic [7:0] mem [0:63];
  logic [7:0] pkt [0:15];
  logic [7:0] reply [0:15];

  logic [2:0]  sck, ncs;
  logic [10:0] a0, ia0, clen0;
  logic [7:0]  q0, id0;
  logic        arm0, wren0, commit0, mosi0, busy0, miso;
  logic        commit_ack = 1'b0;
  logic        arm_ack    = 1'b0;

  always @(posedge clk) q0 <= mem[a0[5:0]];

  joker_spi_cmd #(.CLK_DIV(2), .MAX_LEN(MAXL), .CMD_ID(CMD)) u_dut (
    .clk(clk), .reset(reset),
    .buf_out_hasdata(hasdata), .buf_out_len(len_in), .buf_out_q(q0),
    .buf_out_addr_o(a0), .buf_out_arm(arm0), .buf_out_arm_ack(arm_ack),
    .usb_in_addr_o(ia0), .usb_in_data_o(id0), .usb_in_wren_o(wren0),
    .usb_in_ready(ready), .usb_in_commit(commit0), .usb_in_commit_len(clen0),
    .usb_in_commit_ack(commit_ack),
    .FLASH_SCLK(sck[0]), .FLASH_MOSI(mosi0), .FLASH_nCS(ncs[0]), .FLASH_MISO(miso),
    .busy(busy0)
  );

  // Free-running timing instances: always ready, acks tied high.
  for (genvar k = 1; k < 3; k++) begin : g_x
    localparam int D = (k == 1) ? 1 : 4;
    logic [10:0] a, ia, cl;
    logic [7:0]  q, id;
    logic        arm, wr, cm, mo, bz;
    always @(posedge clk) q <= mem[a[5:0]];
    joker_spi_cmd #(.CLK_DIV(D), .CMD_ID(CMD)) u_x (
      .clk(clk), .reset(rst_x),
      .buf_out_hasdata(hasdata), .buf_out_len(len_in), .buf_out_q(q),
      .buf_out_addr_o(a), .buf_out_arm(arm), .buf_out_arm_ack(1'b1),
      .usb_in_addr_o(ia), .usb_in_data_o(id), .usb_in_wren_o(wr),
      .usb_in_ready(1'b1), .usb_in_commit(cm), .usb_in_commit_len(cl),
      .usb_in_commit_ack(1'b1),
      .FLASH_SCLK(sck[k]), .FLASH_MOSI(mo), .FLASH_nCS(ncs[k]), .FLASH_MISO(1'b0),
      .busy(bz)
    );
  end

  // SCLK period inside a byte must be 2*D cycles; byte-to-byte at most 2*D+4.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    localparam int D = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    time last_t   = 0;
    int  nrise    = 0;
    int  per_seen = 0;
    int  per_bad  = 0;
    always @(posedge sck[g] or negedge ncs[g]) begin
      if (!sck[g]) begin
        nrise = 0;
      end else begin
        if (nrise != 0) begin
          if (nrise % 8 != 0) begin
            per_seen++;
            if (($time - last_t) != time'(20 * D)) per_bad++;
          end else if (($time - last_t) > time'(10 * (2 * D + 4))) begin
            per_bad++;
          end
        end
        last_t = $time;
        nrise++;
      end
    end
  end

  // Flash slave: returns reply[k] for the k-th byte of each nCS window, records MOSI.
  int         bitpos  = 0;
  int         bytek   = 1;
  int         windows = 0;
  int         rises   = 0;
  logic [7:0] msh     = 8'h00;
  logic [7:0] mosi_q[$];
  always @(posedge sck[0] or negedge ncs[0]) begin
    if (!sck[0]) begin
      windows++;
      bitpos = 0;
      bytek  = 1;
      miso   = reply[1][7];
    end else begin
      rises++;
      msh = {msh[6:0], mosi0};
      bitpos++;
      if (bitpos == 8) begin
        mosi_q.push_back(msh);
        bitpos = 0;
        bytek++;
      end
      if (bytek < 16) miso = reply[bytek][7 - bitpos];
    end
  end

  logic [18:0] wr_q[$];
  always @(negedge clk) if (wren0) wr_q.push_back({ia0, id0});

  // Host side: acks after 0..3 cycles, one cycle wide.
  int          cwait = -1, await_ = -1, commits = 0, arms = 0;
  logic [10:0] clen_seen = '0;
  always @(negedge clk) begin
    if (commit_ack) commit_ack = 1'b0;
    else if (commit0) begin
      if (cwait < 0) cwait = $urandom_range(0, 3);
      if (cwait == 0) begin
        commit_ack = 1'b1; commits++; clen_seen = clen0; cwait = -1;
      end else cwait--;
    end
    if (arm_ack) arm_ack = 1'b0;
    else if (arm0) begin
      if (await_ < 0) await_ = $urandom_range(0, 3);
      if (await_ == 0) begin
        arm_ack = 1'b1; arms++; await_ = -1;
      end else await_--;
    end
  end

  int checks = 0, passed = 0, fails = 0;
  int b_wr, b_mosi, b_com, b_arm, b_win, b_rise;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_wr = wr_q.size(); b_mosi = mosi_q.size(); b_com = commits;
    b_arm = arms; b_win = windows; b_rise = rises;
  endtask

  task automatic load(input int n);
    @(negedge clk);
    for (int i = 0; i < 16; i++) mem[i] = pkt[i];
    len_in  = 10'(n);
    hasdata = 1'b1;
  endtask

  task automatic rand_body();
    for (int i = 1; i < 16; i++) begin
      pkt[i]   = 8'($urandom);
      reply[i] = 8'($urandom);
    end
  endtask

  task automatic finish_and_check(input int n);
    int   t;
    logic ok;
    t = 0;
    while (arms == b_arm && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("arm_seen", 32'(arms != b_arm), 1);
    hasdata = 1'b0;
    repeat (3) @(negedge clk);
    ok = (pkt[0] == 8'(CMD)) && (n >= 2) && (n <= MAXL);
    chk("busy_after", busy0, 0);
    chk("ncs_after", ncs[0], 1);
    chk("arm_count", arms - b_arm, 1);
    chk("commit_count", commits - b_com, ok);
    if (ok) chk("commit_len", clen_seen, n);
    chk("ncs_windows", windows - b_win, ok);
    chk("sclk_rises", rises - b_rise, ok ? 8 * (n - 1) : 0);
    chk("in_writes", wr_q.size() - b_wr, ok ? n : 0);
    chk("mosi_bytes", mosi_q.size() - b_mosi, ok ? n - 1 : 0);
    if (ok && (wr_q.size() - b_wr == n)) begin
      for (int k = 0; k < n; k++)
        chk($sformatf("in_byte%0d", k), wr_q[b_wr + k],
            {11'(k), (k == 0) ? 8'(CMD) : reply[k]});
    end
    if (ok && (mosi_q.size() - b_mosi == n - 1)) begin
      for (int k = 1; k < n; k++)
        chk($sformatf("mosi_byte%0d", k), mosi_q[b_mosi + k - 1], pkt[k]);
    end
  endtask

  initial begin
    int t, n;
    reset = 1'b1; rst_x = 1'b1; hasdata = 1'b0; ready = 1'b1; len_in = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) begin pkt[i] = 8'h00; reply[i] = 8'h00; end
    repeat (3) @(negedge clk);
    chk("rst_ncs", ncs[0], 1);
    chk("rst_sclk", sck[0], 0);
    chk("rst_mosi", mosi0, 0);
    chk("rst_in_wr", {wren0, commit0}, 0);
    chk("rst_in_addr", ia0, 0);
    chk("rst_in_data", id0, 0);
    chk("rst_commit_len", clen0, 0);
    chk("rst_out_addr", a0, 0);
    chk("rst_arm", arm0, 0);
    chk("rst_busy", busy0, 0);
    reset = 1'b0; rst_x = 1'b0;

    // Basic transfer, slave answers 0xFF.
    pkt[0] = 8'(CMD); pkt[1] = 8'h02; pkt[2] = 8'h11; pkt[3] = 8'h22; pkt[4] = 8'h33;
    for (int i = 1; i < 16; i++) reply[i] = 8'hFF;
    snap(); load(5); finish_and_check(5);

    // Second reply byte distinct.
    pkt[0] = 8'(CMD); pkt[1] = 8'h05; pkt[2] = 8'h00;
    reply[1] = 8'h3C; reply[2] = 8'hA5;
    snap(); load(3); finish_and_check(3);

    // Wrong command byte, then too short, too long, and the length limits.
    pkt[0] = 8'(CMD + 1);
    snap(); load(3); finish_and_check(3);
    pkt[0] = 8'(CMD);
    snap(); load(1); finish_and_check(1);
    rand_body(); snap(); load(MAXL + 1); finish_and_check(MAXL + 1);
    rand_body(); snap(); load(MAXL); finish_and_check(MAXL);
    rand_body(); snap(); load(2); finish_and_check(2);

    // Host IN buffer not ready: nothing moves until it is.
    rand_body(); ready = 1'b0; snap(); load(4);
    repeat (20) @(negedge clk);
    chk("wait_busy", busy0, 0);
    chk("wait_ncs", ncs[0], 1);
    chk("wait_windows", windows - b_win, 0);
    ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("start_after_ready", busy0, 1);
    finish_and_check(4);

    // Random packets.
    for (int r = 0; r < 8; r++) begin
      rand_body();
      n = $urandom_range(0, 10);
      pkt[0] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(CMD);
      snap(); load(n); finish_and_check(n);
    end

    // Reset during bit 3 of byte 2 aborts; the unreleased packet is then redone.
    rand_body(); pkt[0] = 8'(CMD);
    snap(); load(6);
    t = 0;
    while (!((mosi_q.size() - b_mosi == 1) && (bitpos == 3)) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("reach_byte2_bit3", 32'(t < 2000), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ncs", ncs[0], 1);
    chk("abort_sclk", sck[0], 0);
    chk("abort_busy", busy0, 0);
    repeat (2) @(negedge clk);
    chk("abort_no_commit", commits - b_com, 0);
    chk("abort_no_arm", arms - b_arm, 0);
    reset = 1'b0;
    snap(); finish_and_check(6);

    repeat (50) @(negedge clk);
    chk("div2_period_seen", 32'(g_mon[0].per_seen > 0), 1);
    chk("div2_period_bad", g_mon[0].per_bad, 0);
    chk("div1_period_seen", 32'(g_mon[1].per_seen > 0), 1);
    chk("div1_period_bad", g_mon[1].per_bad, 0);
    chk("div4_period_seen", 32'(g_mon[2].per_seen > 0), 1);
    chk("div4_period_bad", g_mon[2].per_bad, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
